// File: rtl/pwm_cmd_master.sv
// Avalon-MM command master for a PWM block: replays configuration and
// comparator commands as register write bursts, then optionally waits for the PWM trigger.
module pwm_cmd_master #(
  parameter int WAIT_TRIG = 1,
  parameter int TIMEOUT   = 200000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [95:0] cmd_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_maxctr,
  input  logic [3:0]  cfg_mode,
  input  logic        trig_irq,
  output logic [3:0]  M_addr,
  output logic        M_write,
  output logic [31:0] M_writedata,
  input  logic        M_waitrequest,
  output logic        done,
  output logic        timeout,
  output logic [15:0] upd_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFG_WR,
    S_CMD_WR,
    S_WAIT_TRIG
  } state_t;

  localparam logic [2:0]  CFG_LAST = 3'd4;
  localparam logic [2:0]  CMD_LAST = 3'd6;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q;
  logic [15:0] maxctr_q;
  logic [3:0]  mode_q;
  logic [95:0] cmd_q;
  logic [31:0] tmo_q;
  logic [15:0] upd_cnt_q;
  logic        done_d, timeout_d;
  logic        wr_done, wr_last;

  // Config takes priority over a command presented in the same cycle.
  assign cfg_ready = (state_q == S_IDLE);
  assign cmd_ready = (state_q == S_IDLE) && !cfg_valid;
  assign upd_count = upd_cnt_q;

  assign wr_done = M_write && !M_waitrequest;
  assign wr_last = ((state_q == S_CFG_WR) && (idx_q == CFG_LAST)) ||
                   ((state_q == S_CMD_WR) && (idx_q == CMD_LAST));

  // Bus outputs decode purely from registered state so they drop to zero
  // the instant reset is applied and stay put while the slave stalls.
  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    M_write     = 1'b0;
    M_addr      = 4'h0;
    M_writedata = 32'h0;
    unique case (state_q)
      S_CFG_WR: begin
        M_write = 1'b1;
        case (idx_q)
          3'd0: begin
            M_addr      = 4'h8;
            M_writedata = {16'h0, maxctr_q};
          end
          3'd1: begin
            M_addr      = 4'hA;
            M_writedata = {31'h0, mode_q[0]};
          end
          3'd2: begin
            M_addr      = 4'hB;
            M_writedata = {31'h0, mode_q[1]};
          end
          3'd3: begin
            M_addr      = 4'hC;
            M_writedata = {31'h0, mode_q[2]};
          end
          default: begin
            M_addr      = 4'hD;
            M_writedata = {31'h0, mode_q[3]};
          end
        endcase
      end
      S_CMD_WR: begin
        M_write = 1'b1;
        case (idx_q)
          3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
            M_addr      = {1'b0, idx_q};
            M_writedata = {16'h0, cmd_q[{idx_q, 4'h0} +: 16]};
          end
          default: begin
            M_addr      = 4'hF;
            M_writedata = 32'h1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid)      state_d = S_CFG_WR;
        else if (cmd_valid) state_d = S_CMD_WR;
      end
      S_CFG_WR: begin
        if (wr_done && wr_last) state_d = S_IDLE;
      end
      S_CMD_WR: begin
        if (wr_done && wr_last) begin
          if (WAIT_TRIG != 0) begin
            state_d = S_WAIT_TRIG;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_WAIT_TRIG: begin
        // A trigger coinciding with expiry counts as success.
        if (trig_irq) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the latched fields are plain flops, so clearing them on reset is cheap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= 3'd0;
      maxctr_q  <= 16'h0;
      mode_q    <= 4'h0;
      cmd_q     <= 96'h0;
      tmo_q     <= 32'h0;
      upd_cnt_q <= 16'h0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done    <= done_d;
      timeout <= timeout_d;

      if (done_d) upd_cnt_q <= upd_cnt_q + 16'd1;

      // Index restarts on every state change and advances only on completed writes.
      if (state_d != state_q) idx_q <= 3'd0;
      else if (wr_done)       idx_q <= idx_q + 3'd1;

      if (state_q != S_WAIT_TRIG) tmo_q <= 32'h0;
      else                        tmo_q <= tmo_q + 32'd1;

      if (state_q == S_IDLE) begin
        if (cfg_valid) begin
          maxctr_q <= cfg_maxctr;
          mode_q   <= cfg_mode;
        end else if (cmd_valid) begin
          cmd_q <= cmd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_cmd_master.sv
// Directed bench for pwm_cmd_master: config/command write bursts, stalls,
// trigger wait, timeout, counter wrap and mid-sequence reset.
module tb_pwm_cmd_master;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cfg_valid = 1'b0, trig_irq = 1'b0;
  logic [95:0] cmd_data = '0;
  logic [15:0] cfg_maxctr = '0;
  logic [3:0]  cfg_mode = '0;
  logic        cmd_ready, cfg_ready, m_write, done, timeout;
  logic [3:0]  m_addr;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic [15:0] upd_count;

  logic        cmd_valid0 = 1'b0;
  logic        cmd_ready0, cfg_ready0, m_write0, done0, timeout0;
  logic [3:0]  m_addr0;
  logic [31:0] m_writedata0;
  logic [15:0] upd_count0;
  logic        cfg_valid0 = 1'b0;
  logic        m_waitrequest0 = 1'b0;

  int  errors = 0, checks = 0;
  int  cyc = 0;
  int  done_cnt = 0, tmo_cnt = 0, w0_cnt = 0;
  int  a2_cycles = 0, a2_good = 0;
  bit  stall_en = 1'b0;
  int  stall_left = 0;
  logic [31:0] a2_expect = '0;
  wr_t wq[$];

  pwm_cmd_master #(.WAIT_TRIG(1), .TIMEOUT(50)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_maxctr(cfg_maxctr), .cfg_mode(cfg_mode), .trig_irq(trig_irq),
    .M_addr(m_addr), .M_write(m_write), .M_writedata(m_writedata),
    .M_waitrequest(m_waitrequest),
    .done(done), .timeout(timeout), .upd_count(upd_count)
  );

  pwm_cmd_master #(.WAIT_TRIG(0), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_data(cmd_data),
    .cfg_valid(cfg_valid0), .cfg_ready(cfg_ready0),
    .cfg_maxctr(cfg_maxctr), .cfg_mode(cfg_mode), .trig_irq(trig_irq),
    .M_addr(m_addr0), .M_write(m_write0), .M_writedata(m_writedata0),
    .M_waitrequest(m_waitrequest0),
    .done(done0), .timeout(timeout0), .upd_count(upd_count0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave stall model: holds off the address-2 write for stall_left cycles.
  always @(negedge clk) begin
    if (stall_en && m_write && m_addr == 4'h2 && stall_left > 0) begin
      m_waitrequest = 1'b1;
      stall_left    = stall_left - 1;
    end else begin
      m_waitrequest = 1'b0;
    end
  end

  // Bus monitor, sampled mid-cycle after the stall model has settled.
  always @(negedge clk) begin
    #1;
    if (m_write && !m_waitrequest) wq.push_back('{addr: m_addr, data: m_writedata, cyc: cyc});
    if (m_write && m_addr == 4'h2) begin
      a2_cycles++;
      if (m_writedata == a2_expect) a2_good++;
    end
    if (done)     done_cnt++;
    if (timeout)  tmo_cnt++;
    if (m_write0) w0_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wq.size() < n && k < budget) begin
      step();
      k++;
    end
    check("write_count", 32'(wq.size()), 32'(n));
  endtask

  task automatic check_cmd(input int base, input logic [95:0] cmd, input int first_cyc);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("cmd_addr%0d", k), {28'h0, wq[base+k].addr},
            (k == 6) ? 32'hF : 32'(k));
      check($sformatf("cmd_data%0d", k), wq[base+k].data,
            (k == 6) ? 32'h1 : {16'h0, cmd[16*k +: 16]});
      if (first_cyc >= 0)
        check($sformatf("cmd_cyc%0d", k), 32'(wq[base+k].cyc), 32'(first_cyc + k));
    end
  endtask

  task automatic send_cmd(input logic [95:0] d, output int a);
    cmd_data  = d;
    cmd_valid = 1'b1;
    a = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~d;
  endtask

  initial begin
    logic [95:0] c1, c2, c3, c4, c5;
    int a, e, k, t;
    c1 = {16'h0060, 16'h0050, 16'h0040, 16'h0030, 16'h0020, 16'h0010};
    c2 = {16'h0666, 16'h0555, 16'h0444, 16'h0333, 16'h0222, 16'h0111};
    c3 = {16'h0A06, 16'h0A05, 16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01};
    c4 = {16'hBEEF, 16'h1357, 16'h2468, 16'hCAFE, 16'h0F0F, 16'h7777};
    c5 = {16'h9006, 16'h9005, 16'h9004, 16'h9003, 16'h9002, 16'h9001};

    // Reset values.
    step();
    check("rst_m_write", {31'h0, m_write}, 32'h0);
    check("rst_m_addr", {28'h0, m_addr}, 32'h0);
    check("rst_m_wdata", m_writedata, 32'h0);
    step();
    reset_n = 1'b1;
    #1;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    check("rst_upd_count", {16'h0, upd_count}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);

    // Configuration burst; inputs change right after accept.
    step();
    cfg_maxctr = 16'h0400;
    cfg_mode   = 4'h5;
    cfg_valid  = 1'b1;
    a = cyc;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    cfg_maxctr = 16'hFFFF;
    cfg_mode   = 4'hA;
    wait_writes(5, 20);
    check("cfg_a0", {28'h0, wq[0].addr}, 32'h8);
    check("cfg_d0", wq[0].data, 32'h400);
    check("cfg_a1", {28'h0, wq[1].addr}, 32'hA);
    check("cfg_d1", wq[1].data, 32'h1);
    check("cfg_a2", {28'h0, wq[2].addr}, 32'hB);
    check("cfg_d2", wq[2].data, 32'h0);
    check("cfg_a3", {28'h0, wq[3].addr}, 32'hC);
    check("cfg_d3", wq[3].data, 32'h1);
    check("cfg_a4", {28'h0, wq[4].addr}, 32'hD);
    check("cfg_d4", wq[4].data, 32'h0);
    check("cfg_cyc4", 32'(wq[4].cyc), 32'(a + 5));
    step();
    check("cfg_ready_after", {31'h0, cfg_ready}, 32'h1);
    check("cfg_no_write", {31'h0, m_write}, 32'h0);
    check("cfg_no_done", 32'(done_cnt), 32'h0);

    // Command burst, no stalls, trigger 20 cycles into the wait.
    wq.delete();
    send_cmd(c1, a);
    wait_writes(7, 20);
    check_cmd(0, c1, a + 1);
    step();
    check("wait_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("wait_cfg_ready", {31'h0, cfg_ready}, 32'h0);
    repeat (19) step();
    check("wait_no_done", 32'(done_cnt), 32'h0);
    trig_irq = 1'b1;
    @(posedge clk);
    #1;
    trig_irq = 1'b0;
    step();
    check("trig_done", {31'h0, done}, 32'h1);
    check("trig_upd1", {16'h0, upd_count}, 32'h1);
    step();
    check("trig_done_clr", {31'h0, done}, 32'h0);
    check("trig_idle", {31'h0, cmd_ready}, 32'h1);

    // Slave stalls the address-2 write for 3 cycles.
    wq.delete();
    stall_en   = 1'b1;
    stall_left = 3;
    a2_cycles  = 0;
    a2_good    = 0;
    a2_expect  = {16'h0, c2[47:32]};
    send_cmd(c2, a);
    wait_writes(7, 30);
    check_cmd(0, c2, -1);
    check("stall_a2_cycles", 32'(a2_cycles), 32'd4);
    check("stall_a2_held", 32'(a2_good), 32'd4);
    check("stall_w1_cyc", 32'(wq[1].cyc), 32'(a + 2));
    check("stall_w2_cyc", 32'(wq[2].cyc), 32'(a + 6));
    check("stall_last_cyc", 32'(wq[6].cyc), 32'(a + 10));
    stall_en = 1'b0;
    step();
    trig_irq = 1'b1;
    @(posedge clk);
    #1;
    trig_irq = 1'b0;
    step();
    check("stall_done", {31'h0, done}, 32'h1);
    check("stall_upd2", {16'h0, upd_count}, 32'h2);

    // Config and command together; trigger held high through the command burst.
    step();
    wq.delete();
    cfg_maxctr = 16'h1234;
    cfg_mode   = 4'hA;
    cmd_data   = c3;
    cfg_valid  = 1'b1;
    cmd_valid  = 1'b1;
    #1;
    check("both_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    check("both_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    check("both_cmd_accept", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    trig_irq  = 1'b1;
    wait_writes(12, 30);
    @(posedge clk);
    #1;
    trig_irq = 1'b0;
    check("both_a0", {28'h0, wq[0].addr}, 32'h8);
    check("both_d0", wq[0].data, 32'h1234);
    check("both_d1", wq[1].data, 32'h0);
    check("both_d2", wq[2].data, 32'h1);
    check("both_d4", wq[4].data, 32'h1);
    check_cmd(5, c3, -1);
    e = wq[11].cyc + 1;
    step();
    check("ign_trig_wait", {31'h0, cmd_ready}, 32'h0);
    check("ign_trig_done", 32'(done_cnt), 32'd2);

    // No trigger: timeout 50 cycles after entering the wait.
    k = 0;
    t = -1;
    while (k < 80 && t < 0) begin
      if (timeout) t = cyc;
      else begin
        step();
        k++;
      end
    end
    check("tmo_cycle", 32'(t), 32'(e + 50));
    check("tmo_upd", {16'h0, upd_count}, 32'h2);
    check("tmo_no_done", 32'(done_cnt), 32'd2);
    check("tmo_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    step();
    check("tmo_pulse_once", 32'(tmo_cnt), 32'd1);

    // Reset in the middle of a command burst.
    wq.delete();
    send_cmd(c4, a);
    wait_writes(3, 20);
    check("mid_writing", {31'h0, m_write}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_write", {31'h0, m_write}, 32'h0);
    check("mid_rst_addr", {28'h0, m_addr}, 32'h0);
    check("mid_rst_wdata", m_writedata, 32'h0);
    check("mid_rst_upd", {16'h0, upd_count}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    wq.delete();
    repeat (10) step();
    check("mid_no_resume", 32'(wq.size()), 32'h0);
    check("mid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    send_cmd(c5, a);
    wait_writes(7, 20);
    check_cmd(0, c5, a + 1);

    // No-wait instance: done timing and counter wrap.
    repeat (3) step();
    force u_dut0.upd_cnt_q = 16'hFFFF;
    #1;
    release u_dut0.upd_cnt_q;
    #1;
    check("wrap_preset", {16'h0, upd_count0}, 32'hFFFF);
    w0_cnt = 0;
    cmd_valid0 = 1'b1;
    a = cyc;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    k = 0;
    t = -1;
    while (k < 20 && t < 0) begin
      step();
      k++;
      if (done0) t = cyc;
    end
    check("nw_done_cycle", 32'(t), 32'(a + 8));
    check("nw_wrap", {16'h0, upd_count0}, 32'h0);
    check("nw_idle", {31'h0, cmd_ready0}, 32'h1);
    check("nw_write_cycles", 32'(w0_cnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
